// File: rtl/nw_pkg.sv
// Shared types and helpers for the systolic Needleman-Wunsch aligner.
// NW_SATURATE_EN selects saturating score arithmetic in the datapath.
package nw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] DNA_A = 2'd0;
  localparam logic [1:0] DNA_C = 2'd1;
  localparam logic [1:0] DNA_G = 2'd2;
  localparam logic [1:0] DNA_T = 2'd3;

  // Signed add clipped to a w-bit two's complement range (w <= 32).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned        w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/nw_systolic_aligner_pe.sv
// One systolic Needleman-Wunsch cell: holds one s1 character, its own left
// value H(j,k-1) and the diagonal it forwards downstream. NW_SATURATE_EN aware.
module nw_pe
  import nw_pkg::*;
#(
  parameter int unsigned J        = 0,
  parameter int unsigned CWIDTH   = 2,
  parameter int unsigned SWIDTH   = 16,
  parameter int          MATCH    = 1,
  parameter int          MISMATCH = -1,
  parameter int          INDEL    = -1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     active,
  input  logic [CWIDTH-1:0]        c1,
  input  logic [CWIDTH-1:0]        c2,
  input  logic signed [SWIDTH-1:0] up,
  input  logic signed [SWIDTH-1:0] diag,
  output logic signed [SWIDTH-1:0] left,
  output logic signed [SWIDTH-1:0] diag_fwd,
  output logic signed [SWIDTH-1:0] cell_c
);

  localparam logic signed [SWIDTH-1:0] W_MATCH = SWIDTH'(MATCH);
  localparam logic signed [SWIDTH-1:0] W_MIS   = SWIDTH'(MISMATCH);
  localparam logic signed [SWIDTH-1:0] W_GAP   = SWIDTH'(INDEL);
  // Column boundary H(J,-1) and the diagonal PE J+1 needs at its first cell.
  localparam logic signed [SWIDTH-1:0] COL0    = SWIDTH'((int'(J) + 1) * INDEL);
  localparam logic signed [SWIDTH-1:0] DIAG0   = SWIDTH'(int'(J) * INDEL);

  function automatic logic signed [SWIDTH-1:0] add(input logic signed [SWIDTH-1:0] a,
                                                   input logic signed [SWIDTH-1:0] b);
`ifdef NW_SATURATE_EN
    return SWIDTH'(sat_add(64'(a), 64'(b), SWIDTH));
`else
    return a + b;
`endif
  endfunction

  logic [CWIDTH-1:0]        c1_q;
  logic signed [SWIDTH-1:0] w;
  logic signed [SWIDTH-1:0] from_diag;
  logic signed [SWIDTH-1:0] from_up;
  logic signed [SWIDTH-1:0] from_left;
  logic signed [SWIDTH-1:0] best_du;

  // Single-cycle max-of-three cell update.
  always_comb begin
    w         = W_MIS;
    from_diag = '0;
    from_up   = '0;
    from_left = '0;
    best_du   = '0;
    cell_c    = '0;
    if (c1_q == c2) w = W_MATCH;
    from_diag = add(diag, w);
    from_up   = add(up, W_GAP);
    from_left = add(left, W_GAP);
    best_du   = (from_diag > from_up) ? from_diag : from_up;
    cell_c    = (best_du > from_left) ? best_du : from_left;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_q     <= '0;
      left     <= '0;
      diag_fwd <= '0;
    end else if (init) begin
      c1_q     <= c1;
      left     <= COL0;
      diag_fwd <= DIAG0;
    end else if (active) begin
      diag_fwd <= left;
      left     <= cell_c;
    end
  end

endmodule

// File: rtl/nw_systolic_aligner.sv
// Linear systolic Needleman-Wunsch global aligner, one PE per s1 character.
// Define NW_SATURATE_EN for saturating score adds (default: wrap-around).
module nw_systolic_aligner
  import nw_pkg::*;
#(
  parameter int unsigned  LENGTH   = 10,
  parameter int unsigned  CWIDTH   = 2,
  parameter int unsigned  SWIDTH   = 16,
  parameter int           MATCH    = 1,
  parameter int           MISMATCH = -1,
  parameter int           INDEL    = -1,
  localparam int unsigned LWIDTH   = $clog2(LENGTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  input  logic [LWIDTH-1:0]          len1,
  input  logic [LWIDTH-1:0]          len2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SWIDTH-1:0]   score,
  output logic                       err
);

  localparam int unsigned TW = $clog2(2 * LENGTH + 1);
  localparam int unsigned SW = LENGTH * CWIDTH;
  localparam logic signed [SWIDTH-1:0] W_GAP = SWIDTH'(INDEL);

  function automatic logic signed [SWIDTH-1:0] add(input logic signed [SWIDTH-1:0] a,
                                                   input logic signed [SWIDTH-1:0] b);
`ifdef NW_SATURATE_EN
    return SWIDTH'(sat_add(64'(a), 64'(b), SWIDTH));
`else
    return a + b;
`endif
  endfunction

  state_e                   state_q;
  state_e                   state_d;
  logic [SW-1:0]            s2_q;
  logic [LWIDTH-1:0]        len1_q;
  logic [LWIDTH-1:0]        len2_q;
  logic [TW-1:0]            t_q;
  logic [TW-1:0]            last_q;
  logic signed [SWIDTH-1:0] bnd_up;
  logic signed [SWIDTH-1:0] bnd_diag;
  logic [CWIDTH-1:0]        chr_q [LENGTH-1];

  logic signed [SWIDTH-1:0] pe_left [LENGTH];
  logic signed [SWIDTH-1:0] pe_fwd  [LENGTH];
  logic signed [SWIDTH-1:0] pe_cell [LENGTH];
  logic [LENGTH-1:0]        active_c;
  logic signed [SWIDTH-1:0] result_c;
  logic                     accept_c;
  logic                     legal_c;
  logic                     last_step_c;
  logic                     done_hs_c;

  // Handshake decode and wavefront activity of every PE.
  always_comb begin
    accept_c    = in_valid && in_ready;
    legal_c     = (len1 != '0) && (len1 <= LWIDTH'(LENGTH)) &&
                  (len2 != '0) && (len2 <= LWIDTH'(LENGTH));
    last_step_c = (state_q == RUN) && (t_q == last_q);
    done_hs_c   = (state_q == DONE) && out_valid && out_ready;
    active_c    = '0;
    result_c    = '0;
    for (int j = 0; j < int'(LENGTH); j++) begin
      active_c[j] = (state_q == RUN) && (LWIDTH'(j) < len1_q) &&
                    (t_q >= TW'(j)) && ((t_q - TW'(j)) < TW'(len2_q));
      if (LWIDTH'(j) == len1_q - LWIDTH'(1)) result_c = pe_cell[j];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = legal_c ? RUN : DONE;
      RUN:     if (last_step_c) state_d = DONE;
      DONE:    if (done_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Job latch, step counter, row boundary, s2 streaming and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      score     <= '0;
      err       <= 1'b0;
      s2_q      <= '0;
      len1_q    <= '0;
      len2_q    <= '0;
      t_q       <= '0;
      last_q    <= '0;
      bnd_up    <= '0;
      bnd_diag  <= '0;
      for (int j = 0; j < int'(LENGTH) - 1; j++) chr_q[j] <= '0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_q == DONE) && !done_hs_c;
      if (accept_c) begin
        s2_q     <= s2;
        len1_q   <= len1;
        len2_q   <= len2;
        t_q      <= '0;
        last_q   <= TW'(len1) + TW'(len2) - TW'(2);
        bnd_up   <= W_GAP;
        bnd_diag <= '0;
        if (!legal_c) begin
          err   <= 1'b1;
          score <= '0;
        end
      end else if (state_q == RUN) begin
        t_q      <= t_q + TW'(1);
        s2_q     <= s2_q >> CWIDTH;
        bnd_diag <= bnd_up;
        bnd_up   <= add(bnd_up, W_GAP);
        chr_q[0] <= s2_q[CWIDTH-1:0];
        for (int j = 1; j < int'(LENGTH) - 1; j++) chr_q[j] <= chr_q[j-1];
        if (last_step_c) score <= result_c;
      end
      if (done_hs_c) err <= 1'b0;
    end
  end

  // PE 0 takes the row boundary and the head of s2; PE j>0 is fed by PE j-1.
  for (genvar j = 0; j < int'(LENGTH); j++) begin : g_pe
    logic [CWIDTH-1:0]        c2_w;
    logic signed [SWIDTH-1:0] up_w;
    logic signed [SWIDTH-1:0] diag_w;
    if (j == 0) begin : g_head
      assign c2_w   = s2_q[CWIDTH-1:0];
      assign up_w   = bnd_up;
      assign diag_w = bnd_diag;
    end else begin : g_body
      assign c2_w   = chr_q[j-1];
      assign up_w   = pe_left[j-1];
      assign diag_w = pe_fwd[j-1];
    end

    nw_pe #(
      .J        (j),
      .CWIDTH   (CWIDTH),
      .SWIDTH   (SWIDTH),
      .MATCH    (MATCH),
      .MISMATCH (MISMATCH),
      .INDEL    (INDEL)
    ) u_pe (
      .clk      (clk),
      .rst      (rst),
      .init     (accept_c),
      .active   (active_c[j]),
      .c1       (s1[j*CWIDTH +: CWIDTH]),
      .c2       (c2_w),
      .up       (up_w),
      .diag     (diag_w),
      .left     (pe_left[j]),
      .diag_fwd (pe_fwd[j]),
      .cell_c   (pe_cell[j])
    );
  end

endmodule

// File: tb/tb_nw_systolic_aligner.sv
// Directed bench for nw_systolic_aligner: vector table plus backpressure and reset sequences.
module tb_nw_systolic_aligner;
  import nw_pkg::*;

  localparam int unsigned LENGTH = 10;
  localparam int unsigned CWIDTH = 2;
  localparam int unsigned SWIDTH = 16;
  localparam int unsigned LWIDTH = $clog2(LENGTH + 1);
  localparam int unsigned SW     = LENGTH * CWIDTH;
  localparam int          NV     = 12;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     out_ready = 1'b0;
  logic [SW-1:0]            s1 = '0;
  logic [SW-1:0]            s2 = '0;
  logic [LWIDTH-1:0]        len1 = '0;
  logic [LWIDTH-1:0]        len2 = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic                     err;
  logic signed [SWIDTH-1:0] score;

  int checks = 0;
  int failures = 0;

  nw_systolic_aligner #(
    .LENGTH   (LENGTH),
    .CWIDTH   (CWIDTH),
    .SWIDTH   (SWIDTH),
    .MATCH    (1),
    .MISMATCH (-1),
    .INDEL    (-1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s1        (s1),
    .s2        (s2),
    .len1      (len1),
    .len2      (len2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .score     (score),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    int            l1;
    int            l2;
    int            sc;
    bit            er;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [SW-1:0] pack(input string s);
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < int'(LENGTH); i++) begin
      case (s[i])
        "C":     v[i*CWIDTH +: CWIDTH] = DNA_C;
        "G":     v[i*CWIDTH +: CWIDTH] = DNA_G;
        "T":     v[i*CWIDTH +: CWIDTH] = DNA_T;
        default: v[i*CWIDTH +: CWIDTH] = DNA_A;
      endcase
    end
    return v;
  endfunction

  function automatic vec_t mk(input string a, input string b, input int l1, input int l2,
                              input int sc, input bit er);
    vec_t v;
    v.a  = pack(a);
    v.b  = pack(b);
    v.l1 = l1;
    v.l2 = l2;
    v.sc = sc;
    v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic start_job(input logic [SW-1:0] a, input logic [SW-1:0] b,
                           input int l1, input int l2, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_before"}, int'(in_ready), 1);
    s1       = a;
    s2       = b;
    len1     = LWIDTH'(l1);
    len2     = LWIDTH'(l2);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_job(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_cleared"}, int'(out_valid), 0);
    check({name, "_ready_back"}, int'(in_ready), 1);
    check({name, "_err_cleared"}, int'(err), 0);
  endtask

  initial begin
    int    lat;
    int    seen;
    string nm;

    vecs[0]  = mk("ACGT", "ACGT", 4, 4, 4, 1'b0);
    vecs[1]  = mk("AAAA", "TTTT", 4, 4, -4, 1'b0);
    vecs[2]  = mk("GATTACA", "GCATGCT", 7, 7, 0, 1'b0);
    vecs[3]  = mk("A", "AAAAAAAA", 1, 8, -6, 1'b0);
    vecs[4]  = mk("ACGTACGTAC", "ACGTACGTAC", 10, 10, 10, 1'b0);
    vecs[5]  = mk("A", "A", 1, 1, 1, 1'b0);
    vecs[6]  = mk("A", "C", 1, 1, -1, 1'b0);
    vecs[7]  = mk("AC", "A", 2, 1, 0, 1'b0);
    vecs[8]  = mk("AAAA", "ATTT", 2, 2, 0, 1'b0);
    vecs[9]  = mk("ACGTACGTAC", "C", 10, 1, -8, 1'b0);
    vecs[10] = mk("ACGT", "ACGT", 4, 11, 0, 1'b1);
    vecs[11] = mk("ACGT", "ACG", 4, 3, 2, 1'b0);

    repeat (2) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_score", int'(score), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("vec%0d", i);
      start_job(vecs[i].a, vecs[i].b, vecs[i].l1, vecs[i].l2, nm);
      wait_result(lat);
      check({nm, "_latency"}, lat, vecs[i].er ? 1 : vecs[i].l1 + vecs[i].l2);
      check({nm, "_score"}, int'(score), vecs[i].sc);
      check({nm, "_err"}, int'(err), int'(vecs[i].er));
      check({nm, "_busy"}, int'(in_ready), 0);
      finish_job(nm);
    end

    // Result held under backpressure while a new request waits.
    start_job(pack("ACGT"), pack("ACGT"), 4, 4, "bp");
    wait_result(lat);
    check("bp_latency", lat, 8);
    s1       = pack("AAAA");
    s2       = pack("TTTT");
    len1     = LWIDTH'(4);
    len2     = LWIDTH'(4);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_score_c%0d", c), int'(score), 4);
      check($sformatf("bp_valid_c%0d", c), int'(out_valid), 1);
      check($sformatf("bp_ready_c%0d", c), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_hs_valid_low", int'(out_valid), 0);
    check("bp_hs_ready_high", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accepted", int'(in_ready), 0);
    wait_result(lat);
    check("bp_next_latency", lat, 8);
    check("bp_next_score", int'(score), -4);
    finish_job("bp_next");

    // Reset mid-run drops the job.
    start_job(pack("GATTACA"), pack("GCATGCT"), 7, 7, "mrst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_in_ready", int'(in_ready), 1);
    check("mrst_score", int'(score), 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mrst_no_result", seen, 0);

    start_job(pack("ACGT"), pack("ACGT"), 0, 4, "len0");
    wait_result(lat);
    check("len0_latency", lat, 1);
    check("len0_err", int'(err), 1);
    check("len0_score", int'(score), 0);
    finish_job("len0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
